// File: rtl/act3_ctrl_pkg.sv
// Shared types and helpers for the Activity 3 run controller and its three-flop core.
package act3_ctrl_pkg;

  localparam int unsigned CORE_W = 3;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_CLR  = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'b00,
    FSM_RUN  = 2'b01,
    FSM_STEP = 2'b10,
    FSM_DONE = 2'b11
  } fsm_e;

  typedef enum logic [1:0] {
    RSN_NORMAL = 2'b00,
    RSN_BREAK  = 2'b01,
    RSN_HALT   = 2'b10,
    RSN_LIMIT  = 2'b11
  } reason_e;

  localparam logic [CORE_W-1:0] CORE_RST_STATE = 3'b000;

  // Core next-state equations on {a,b,c}.
  function automatic logic [CORE_W-1:0] core_next(input logic [CORE_W-1:0] s);
    logic a;
    logic b;
    logic c;
    a = s[2];
    b = s[1];
    c = s[0];
    return {~(b | c), a & c, a ^ b};
  endfunction

endpackage

// File: rtl/act3_core.sv
// Activity 3 three-flop state machine with clock-enable and synchronous clear.
module act3_core
  import act3_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [CORE_W-1:0] state_q,
  output logic              y
);

  logic [CORE_W-1:0] state_d;
  logic              y_d;
  logic              y_q;

  // y is registered from the next state so it always tracks state_q.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CORE_RST_STATE;
    end else if (en) begin
      state_d = core_next(state_q);
    end
    y_d = state_d[2] | state_d[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CORE_RST_STATE;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/act3_run_controller.sv
// Command sequencer for the Activity 3 core: clear, free-run, step and halt with
// break-state / advance-limit stops, advance counting and stop-reason reporting.
module act3_run_controller
  import act3_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RUN_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              break_en,
  input  logic [CORE_W-1:0] break_state,
  output logic [CORE_W-1:0] state_q,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [1:0]        stop_reason,
  output logic [CNT_W-1:0]  adv_cnt
);

  localparam int unsigned   CW1     = CNT_W + 1;
  localparam logic [CW1-1:0] LIMIT_V = CW1'(RUN_LIMIT);

  fsm_e             fsm_q, fsm_d;
  reason_e          reason_q, reason_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] adv_q, adv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e               op;
  logic              accept;
  logic              halt_acc;
  logic              clr;
  logic              limit_hit;
  logic [CNT_W-1:0]  adv_inc;
  logic [CORE_W-1:0] core_nxt;

  act3_core u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (busy_q),
    .clr     (clr),
    .state_q (state_q),
    .y       (y)
  );

  assign op       = op_e'(cmd_op);
  assign core_nxt = core_next(state_q);

  // While advancing, only a HALT may be accepted.
  always_comb begin
    cmd_ready = 1'b0;
    case (fsm_q)
      FSM_IDLE: cmd_ready = 1'b1;
      FSM_RUN,
      FSM_STEP: cmd_ready = (op == OP_HALT);
      default:  cmd_ready = 1'b0;
    endcase
  end

  assign accept    = cmd_valid & cmd_ready;
  assign halt_acc  = accept & (op == OP_HALT);
  assign adv_inc   = (adv_q == '1) ? adv_q : adv_q + CNT_W'(1);
  assign limit_hit = (RUN_LIMIT != 0) && (({1'b0, adv_q} + CW1'(1)) == LIMIT_V);

  always_comb begin
    fsm_d       = fsm_q;
    reason_d    = reason_q;
    remaining_d = remaining_q;
    adv_d       = adv_q;
    clr         = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        if (accept) begin
          adv_d    = '0;
          reason_d = RSN_NORMAL;
          case (op)
            OP_CLR: begin
              clr   = 1'b1;
              fsm_d = FSM_DONE;
            end
            OP_RUN:  fsm_d = FSM_RUN;
            OP_STEP: begin
              remaining_d = cmd_count;
              fsm_d       = (cmd_count == '0) ? FSM_DONE : FSM_STEP;
            end
            default: fsm_d = FSM_DONE;
          endcase
        end
      end
      FSM_RUN: begin
        adv_d = adv_inc;
        if (halt_acc) begin
          reason_d = RSN_HALT;
          fsm_d    = FSM_DONE;
        end else if (break_en && (core_nxt == break_state)) begin
          reason_d = RSN_BREAK;
          fsm_d    = FSM_DONE;
        end else if (limit_hit) begin
          reason_d = RSN_LIMIT;
          fsm_d    = FSM_DONE;
        end
      end
      FSM_STEP: begin
        adv_d       = adv_inc;
        remaining_d = remaining_q - CNT_W'(1);
        if (halt_acc) begin
          reason_d = RSN_HALT;
          fsm_d    = FSM_DONE;
        end else if (remaining_q == CNT_W'(1)) begin
          reason_d = RSN_NORMAL;
          fsm_d    = FSM_DONE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
    busy_d = (fsm_d == FSM_RUN) || (fsm_d == FSM_STEP);
    done_d = (fsm_d == FSM_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= FSM_IDLE;
      reason_q    <= RSN_NORMAL;
      remaining_q <= '0;
      adv_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      reason_q    <= reason_d;
      remaining_q <= remaining_d;
      adv_q       <= adv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stop_reason = reason_q;
  assign adv_cnt     = adv_q;

endmodule
